// File: rtl/micro_pkg.sv
// Shared defaults and FSM state encoding for the micro datapath register file.
package micro_pkg;

  localparam int REG_W     = 16;
  localparam int REG_DEPTH = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_lane_merge.sv
// Per-byte-lane select between old data, port A and port B (B has priority).
module regfile_lane_merge #(
  parameter int WIDTH = 16,
  parameter int NB    = WIDTH / 8
) (
  input  logic [WIDTH-1:0] old_data,
  input  logic [WIDTH-1:0] a_data,
  input  logic [NB-1:0]    a_en,
  input  logic [WIDTH-1:0] b_data,
  input  logic [NB-1:0]    b_en,
  output logic [WIDTH-1:0] merged
);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign merged[8*gi +: 8] = b_en[gi] ? b_data[8*gi +: 8] :
                                 a_en[gi] ? a_data[8*gi +: 8] :
                                            old_data[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Two-read / two-write register file with byte enables, optional write bypass,
// clear sweep sequencer and a never-bypassed monitor port.
module regfile_mp
  import micro_pkg::*;
#(
  parameter int WIDTH   = REG_W,
  parameter int DEPTH   = REG_DEPTH,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0,
  localparam int AW     = $clog2(DEPTH),
  localparam int NB     = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic             ready,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic [AW-1:0]    wa_a,
  input  logic [AW-1:0]    wa_b,
  input  logic [NB-1:0]    we_a,
  input  logic [NB-1:0]    we_b,
  input  logic [WIDTH-1:0] wd_a,
  input  logic [WIDTH-1:0] wd_b,
  input  logic [AW-1:0]    monitor_sel,
  output logic [WIDTH-1:0] monitor_data,
  output logic             led
);

  state_t            state_reg;
  logic [AW-1:0]     ptr_reg;
  logic              ready_reg;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              write_ok;
  logic              collide;
  logic [NB-1:0]     en_a;
  logic [NB-1:0]     en_b;
  logic [NB-1:0]     en_a_mem;
  logic [NB-1:0]     en_b_mem;
  logic [WIDTH-1:0]  wr_b_word;

  assign write_ok = (state_reg == ST_IDLE) && !reset;
  assign collide  = (wa_a == wa_b);
  assign en_a     = we_a & {NB{write_ok && !(R0_ZERO != 0 && wa_a == '0)}};
  assign en_b     = we_b & {NB{write_ok && !(R0_ZERO != 0 && wa_b == '0)}};

  // On an address collision both ports are folded into one merged write at wa_b;
  // lanes enabled on neither port are never written, so old_data is irrelevant.
  assign en_a_mem = collide ? '0 : en_a;
  assign en_b_mem = en_b | (collide ? en_a : '0);

  regfile_lane_merge #(.WIDTH(WIDTH), .NB(NB)) u_wr_merge (
    .old_data (wd_b),
    .a_data   (wd_a),
    .a_en     (collide ? en_a : '0),
    .b_data   (wd_b),
    .b_en     (en_b),
    .merged   (wr_b_word)
  );

  always_ff @(posedge clk) begin
    if (!reset && state_reg == ST_CLEAR) begin
      mem[ptr_reg] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (en_a_mem[i]) mem[wa_a][8*i +: 8] <= wd_a[8*i +: 8];
        if (en_b_mem[i]) mem[wa_b][8*i +: 8] <= wr_b_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          if (clr) begin
            ptr_reg <= '0;
          end else if (ptr_reg == AW'(DEPTH - 1)) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            ready_reg <= 1'b1;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
            ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_CLEAR;
          ptr_reg   <= '0;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_reg;

  logic [AW-1:0]    ra      [2];
  logic [WIDTH-1:0] rd_val  [2];

  assign ra[0] = ra1;
  assign ra[1] = ra2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      logic [WIDTH-1:0] stored;
      logic [WIDTH-1:0] fwd;
      logic [NB-1:0]    fa_en;
      logic [NB-1:0]    fb_en;

      assign stored = (R0_ZERO != 0 && ra[gi] == '0) ? '0 : mem[ra[gi]];
      assign fa_en  = (BYPASS != 0 && wa_a == ra[gi]) ? en_a : '0;
      assign fb_en  = (BYPASS != 0 && wa_b == ra[gi]) ? en_b : '0;

      regfile_lane_merge #(.WIDTH(WIDTH), .NB(NB)) u_byp_merge (
        .old_data (stored),
        .a_data   (wd_a),
        .a_en     (fa_en),
        .b_data   (wd_b),
        .b_en     (fb_en),
        .merged   (fwd)
      );

      assign rd_val[gi] = (state_reg == ST_IDLE) ? fwd : '0;
    end
  endgenerate

  assign rd1 = rd_val[0];
  assign rd2 = rd_val[1];

  assign monitor_data = (state_reg != ST_IDLE) ? '0 :
                        (R0_ZERO != 0 && monitor_sel == '0) ? '0 : mem[monitor_sel];
  assign led = (state_reg == ST_IDLE && R0_ZERO == 0) ? mem[0][0] : 1'b0;

endmodule
